// File: rtl/operand_stall_unit.sv
// Decode-stage hazard controller: operand select, stall/bubble generation, mul/div occupancy, stall stats.
// Operand select and hold/bubble/issue are combinational; stall_reason, stall_cycles, deadlock are one-cycle registered.
package operand_stall_pkg;
   typedef struct packed {
      logic        hit;
      logic        resolved;
      logic [31:0] value;
   } fwd_result_t;
endpackage

module operand_stall_unit
   import operand_stall_pkg::*;
#(
   parameter int MULDIV_CYCLES = 4,
   parameter int MAX_STALL     = 64
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        flush,
   input  logic        id_valid,
   input  logic        id_uses_rs,
   input  logic        id_uses_rt,
   input  logic        id_start_muldiv,
   input  logic        id_reads_hilo,
   input  fwd_result_t fwd_rs,
   input  fwd_result_t fwd_rt,
   input  logic [31:0] rf_rs,
   input  logic [31:0] rf_rt,
   output logic [31:0] operand_a,
   output logic [31:0] operand_b,
   output logic        hold,
   output logic        bubble,
   output logic        issue,
   output logic        muldiv_busy,
   output logic [1:0]  stall_reason,
   output logic [31:0] stall_cycles,
   output logic        deadlock
);

   localparam logic [3:0] MD_LOAD  = 4'(MULDIV_CYCLES);
   localparam logic [7:0] RUN_MAX  = 8'(MAX_STALL);
   localparam logic [7:0] RUN_LAST = 8'(MAX_STALL - 1);

   logic [3:0] cnt;
   logic [7:0] run;
   logic       rs_ok;
   logic       rt_ok;
   logic       data_haz;
   logic       md_haz;
   logic       stall;

   assign operand_a = fwd_rs.hit ? fwd_rs.value : rf_rs;
   assign operand_b = fwd_rt.hit ? fwd_rt.value : rf_rt;

   assign rs_ok    = !id_uses_rs | !fwd_rs.hit | fwd_rs.resolved;
   assign rt_ok    = !id_uses_rt | !fwd_rt.hit | fwd_rt.resolved;
   assign data_haz = !(rs_ok & rt_ok);

   assign muldiv_busy = (cnt != 4'd0);
   assign md_haz      = muldiv_busy & (id_start_muldiv | id_reads_hilo);

   // A flushed instruction never stalls, so flush also breaks the watchdog run.
   assign stall  = id_valid & !flush & (data_haz | md_haz);
   assign hold   = stall;
   assign bubble = stall;
   assign issue  = id_valid & !flush & !stall;

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt          <= '0;
         stall_reason <= '0;
         stall_cycles <= '0;
         run          <= '0;
         deadlock     <= 1'b0;
      end else begin
         if (issue && id_start_muldiv)
            cnt <= MD_LOAD;
         else if (cnt != 4'd0)
            cnt <= cnt - 4'd1;

         stall_reason <= {md_haz & stall, data_haz & stall};

         if (stall)
            stall_cycles <= stall_cycles + 32'd1;

         if (!stall)
            run <= '0;
         else if (run != RUN_MAX)
            run <= run + 8'd1;

         // Set on the edge that completes the MAX_STALL-th consecutive hold cycle.
         if (stall && run >= RUN_LAST)
            deadlock <= 1'b1;
      end
   end

endmodule

// File: tb/tb_operand_stall_unit.sv
// Directed bench for operand_stall_unit: driver queues per-cycle expectations, monitor checks them at negedge.
module tb_operand_stall_unit;
   import operand_stall_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic        flush;
   logic        id_valid;
   logic        id_uses_rs;
   logic        id_uses_rt;
   logic        id_start_muldiv;
   logic        id_reads_hilo;
   fwd_result_t fwd_rs;
   fwd_result_t fwd_rt;
   logic [31:0] rf_rs;
   logic [31:0] rf_rt;
   logic [31:0] operand_a;
   logic [31:0] operand_b;
   logic        hold;
   logic        bubble;
   logic        issue;
   logic        muldiv_busy;
   logic [1:0]  stall_reason;
   logic [31:0] stall_cycles;
   logic        deadlock;

   operand_stall_unit #(.MULDIV_CYCLES(4), .MAX_STALL(64)) dut (
      .clock(clock), .reset(reset), .flush(flush), .id_valid(id_valid),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .id_start_muldiv(id_start_muldiv), .id_reads_hilo(id_reads_hilo),
      .fwd_rs(fwd_rs), .fwd_rt(fwd_rt), .rf_rs(rf_rs), .rf_rt(rf_rt),
      .operand_a(operand_a), .operand_b(operand_b), .hold(hold), .bubble(bubble),
      .issue(issue), .muldiv_busy(muldiv_busy), .stall_reason(stall_reason),
      .stall_cycles(stall_cycles), .deadlock(deadlock)
   );

   always #5 clock = ~clock;

   localparam int MA = 1, MB = 2, MH = 4, MI = 8, MBZ = 16, MR = 32, MC = 64, MD = 128;

   typedef struct {
      string       name;
      int          mask;
      logic [31:0] a;
      logic [31:0] b;
      logic        hold;
      logic        issue;
      logic        busy;
      logic [1:0]  reason;
      logic [31:0] cyc;
      logic        dl;
   } exp_t;

   exp_t expq[$];
   exp_t e;
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic push(input string nm, input int mask, input logic [31:0] a, input logic [31:0] b,
                       input logic h, input logic iss, input logic bz, input logic [1:0] r,
                       input logic [31:0] c, input logic d);
      exp_t x;
      x.name = nm; x.mask = mask; x.a = a; x.b = b; x.hold = h; x.issue = iss;
      x.busy = bz; x.reason = r; x.cyc = c; x.dl = d;
      expq.push_back(x);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   always @(negedge clock) begin
      if (expq.size() != 0) begin
         e = expq.pop_front();
         if ((e.mask & MA) != 0)  chk({e.name, "/operand_a"}, operand_a, e.a);
         if ((e.mask & MB) != 0)  chk({e.name, "/operand_b"}, operand_b, e.b);
         if ((e.mask & MH) != 0) begin
            chk({e.name, "/hold"}, 32'(hold), 32'(e.hold));
            chk({e.name, "/bubble"}, 32'(bubble), 32'(e.hold));
         end
         if ((e.mask & MI) != 0)  chk({e.name, "/issue"}, 32'(issue), 32'(e.issue));
         if ((e.mask & MBZ) != 0) chk({e.name, "/muldiv_busy"}, 32'(muldiv_busy), 32'(e.busy));
         if ((e.mask & MR) != 0)  chk({e.name, "/stall_reason"}, 32'(stall_reason), 32'(e.reason));
         if ((e.mask & MC) != 0)  chk({e.name, "/stall_cycles"}, stall_cycles, e.cyc);
         if ((e.mask & MD) != 0)  chk({e.name, "/deadlock"}, 32'(deadlock), 32'(e.dl));
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      flush = 0; id_valid = 0; id_uses_rs = 0; id_uses_rt = 0;
      id_start_muldiv = 0; id_reads_hilo = 0;
      fwd_rs = '0; fwd_rt = '0; rf_rs = '0; rf_rt = '0;
   endtask

   initial begin
      reset = 1;
      idle();
      repeat (2) tick();
      reset = 0;
      push("reset", MH|MI|MBZ|MR|MC|MD, 0, 0, 0, 0, 0, 0, 0, 0);

      // Forwarded operand and register-file fallback
      tick(); idle(); id_valid = 1; id_uses_rs = 1;
      fwd_rs = {1'b1, 1'b1, 32'hDEADBEEF}; rf_rs = 32'h11; rf_rt = 32'h22;
      push("fwd", MA|MB|MH|MI|MR|MC, 32'hDEADBEEF, 32'h22, 0, 1, 0, 0, 0, 0);
      tick(); fwd_rs = {1'b0, 1'b0, 32'hDEADBEEF};
      push("rf", MA|MH|MI, 32'h11, 0, 0, 1, 0, 0, 0, 0);

      // Unresolved load on rt for three cycles
      for (int i = 0; i < 3; i++) begin
         tick(); idle(); id_valid = 1; id_uses_rt = 1;
         fwd_rt = {1'b1, 1'b0, 32'h0}; rf_rt = 32'h99;
         push("load", MB|MH|MI|MR|MC, 0, 32'h0, 1, 0, 0, (i == 0) ? 2'd0 : 2'd1, 32'(i), 0);
      end
      tick(); fwd_rt = {1'b1, 1'b1, 32'h42};
      push("load_go", MB|MH|MI|MR|MC, 0, 32'h42, 0, 1, 0, 1, 3, 0);
      tick(); idle();
      push("load_after", MH|MR|MC, 0, 0, 0, 0, 0, 0, 3, 0);

      // mult then mflo: held four cycles
      tick(); idle(); id_valid = 1; id_start_muldiv = 1;
      push("mult", MH|MI|MBZ, 0, 0, 0, 1, 0, 0, 0, 0);
      for (int i = 1; i <= 4; i++) begin
         tick(); idle(); id_valid = 1; id_reads_hilo = 1;
         push("mflo_wait", MH|MI|MBZ|MR|MC, 0, 0, 1, 0, 1, (i == 1) ? 2'd0 : 2'd2, 32'(2 + i), 0);
      end
      tick();
      push("mflo_go", MH|MI|MBZ|MR|MC, 0, 0, 0, 1, 0, 2, 7, 0);
      tick(); idle();
      push("md_after", MR|MC, 0, 0, 0, 0, 0, 0, 7, 0);

      // Unresolved hit on an unused operand: no stall
      tick(); idle(); id_valid = 1; fwd_rs = {1'b1, 1'b0, 32'h5}; rf_rs = 32'h77;
      push("unused_rs", MA|MH|MI, 32'h5, 0, 0, 1, 0, 0, 7, 0);

      // Combined hazard, then flush while stalled
      tick(); idle(); id_valid = 1; id_start_muldiv = 1;
      push("mult2", MH|MI|MBZ, 0, 0, 0, 1, 0, 0, 7, 0);
      tick(); idle(); id_valid = 1; id_reads_hilo = 1; id_uses_rs = 1; fwd_rs = {1'b1, 1'b0, 32'h0};
      push("both1", MH|MI|MBZ|MR|MC, 0, 0, 1, 0, 1, 0, 7, 0);
      tick();
      push("both2", MH|MI|MBZ|MR|MC, 0, 0, 1, 0, 1, 3, 8, 0);
      tick(); flush = 1;
      push("flush", MH|MI|MBZ|MR|MC, 0, 0, 0, 0, 1, 3, 9, 0);
      tick(); idle();
      push("flush_cnt1", MBZ|MR|MC, 0, 0, 0, 0, 1, 0, 9, 0);
      tick();
      push("flush_cnt0", MBZ|MC, 0, 0, 0, 0, 0, 0, 9, 0);

      // Watchdog: 63 holds, flush breaks the run, then 64 holds
      for (int j = 1; j <= 63; j++) begin
         tick(); idle(); id_valid = 1; id_uses_rs = 1; fwd_rs = {1'b1, 1'b0, 32'h0};
         push("dl_run1", MH|MC|MD, 0, 0, 1, 0, 0, 0, 32'(8 + j), 0);
      end
      tick(); flush = 1;
      push("dl_flush", MH|MC|MD, 0, 0, 0, 0, 0, 0, 72, 0);
      for (int j = 1; j <= 64; j++) begin
         tick(); flush = 0;
         push("dl_run2", MH|MC|MD, 0, 0, 1, 0, 0, 0, 32'(71 + j), 0);
      end
      tick(); idle();
      push("dl_set", MH|MC|MD, 0, 0, 0, 0, 0, 0, 136, 1);
      for (int j = 0; j < 3; j++) begin
         tick();
         push("dl_sticky", MD, 0, 0, 0, 0, 0, 0, 0, 1);
      end
      tick(); reset = 1;
      tick(); reset = 0;
      push("dl_reset", MC|MD|MR, 0, 0, 0, 0, 0, 0, 0, 0);

      // Reset while mul/div busy
      tick(); idle(); id_valid = 1; id_start_muldiv = 1;
      push("rst_mult", MI|MBZ, 0, 0, 0, 1, 0, 0, 0, 0);
      tick(); idle(); id_valid = 1; id_reads_hilo = 1;
      push("rst_mflo", MH|MBZ, 0, 0, 1, 0, 1, 0, 0, 0);
      tick(); reset = 1;
      tick(); reset = 0; idle();
      push("rst_mid", MBZ|MR|MC|MD, 0, 0, 0, 0, 0, 0, 0, 0);

      repeat (3) tick();
      n_cmp++;
      if (expq.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending, expected 0", expq.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
